itof_pipe: RTL

Parametrised, elastic, pipelined integer-to-single-precision converter. Next generation of the fixed 32-bit, 2-stage `itof`. Adds:
- configurable input width and pipeline depth;
- a per-operation signed/unsigned select;
- a transaction tag;
- valid/ready flow control with bubble collapsing.

It sits in the FPU conversion path between the issue queue and the FP writeback arbiter.

---
 rtl/itof_pkg.sv | 24 ++
 rtl/itof_lzc.sv | 24 ++
 rtl/itof_pipe.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/itof_pkg.sv
// itof_pkg: binary32 field constants and the result payload shared by the itof_pipe converter.
// The sticky field exists only when ITOF_INEXACT_EN is defined.
package itof_pkg;

    localparam int SIGN_W = 1;
    localparam int EXP_W  = 8;
    localparam int MAN_W  = 23;
    localparam int BIAS   = 127;

    // The tag rides in a parallel register because its width is a per-instance parameter.
    typedef struct packed {
        logic [SIGN_W-1:0] sign;
        logic [EXP_W-1:0]  exponent;
        logic [MAN_W-1:0]  mantissa;
`ifdef ITOF_INEXACT_EN
        logic              sticky;
`endif
    } result_t;

    function automatic int lzc_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/itof_lzc.sv
// itof_lzc: leading-zero counter over W bits; an all-zero input reports W and raises zero.
module itof_lzc
    import itof_pkg::*;
#(
    parameter  int W  = 32,
    localparam int CW = lzc_width(W)
) (
    input  logic [W-1:0]  d,
    output logic [CW-1:0] cnt,
    output logic          zero
);

    // Scanning upward lets the highest set bit win.
    always_comb begin
        cnt  = CW'(W);
        zero = (d == '0);
        for (int i = 0; i < W; i++) begin
            if (d[i]) begin
                cnt = CW'(W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/itof_pipe.sv
// itof_pipe: elastic IW-bit integer to binary32 converter, RNE rounding, 1..3 register stages.
// Defining ITOF_INEXACT_EN adds out_inexact and carries the sticky bit through the output stage.
module itof_pipe
    import itof_pkg::*;
#(
    parameter int IW     = 32,
    parameter int NSTAGE = 2,
    parameter int TAGW   = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IW-1:0]   in_data,
    input  logic            in_signed,
    input  logic [TAGW-1:0] in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_data,
    output logic [TAGW-1:0] out_tag
`ifdef ITOF_INEXACT_EN
    ,
    output logic            out_inexact
`endif
);

    localparam int LZW     = lzc_width(IW);
    localparam int NW      = (IW < MAN_W + 3) ? MAN_W + 3 : IW;
    localparam int PAD     = NW - IW;
    localparam int OUT_STG = NSTAGE - 1;

    logic [NSTAGE-1:0] v_q;
    logic [NSTAGE-1:0] v_d;
    logic [NSTAGE-1:0] ready;
    logic [NSTAGE-1:0] ld;
    logic              rdy_acc;

    // A stage is ready when it is empty or everything below it can drain this cycle.
    always_comb begin
        rdy_acc = out_ready;
        ready   = '0;
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            rdy_acc  = ~v_q[k] | rdy_acc;
            ready[k] = rdy_acc;
        end
        ld     = '0;
        v_d    = v_q;
        ld[0]  = ready[0] & in_valid;
        v_d[0] = ready[0] ? in_valid : v_q[0];
        for (int k = 1; k < NSTAGE; k++) begin
            ld[k]  = ready[k] & v_q[k-1];
            v_d[k] = ready[k] ? v_q[k-1] : v_q[k];
        end
    end

    logic          a_sign;
    logic [IW-1:0] a_mag;

    always_comb begin
        a_sign = in_signed & in_data[IW-1];
        a_mag  = a_sign ? (~in_data + IW'(1)) : in_data;
    end

    logic            bi_sign;
    logic [IW-1:0]   bi_mag;
    logic [TAGW-1:0] bi_tag;

    if (NSTAGE == 3) begin : g_reg_a
        logic            ra_sign_q, ra_sign_d;
        logic [IW-1:0]   ra_mag_q, ra_mag_d;
        logic [TAGW-1:0] ra_tag_q, ra_tag_d;

        always_comb begin
            ra_sign_d = ra_sign_q;
            ra_mag_d  = ra_mag_q;
            ra_tag_d  = ra_tag_q;
            if (ld[0]) begin
                ra_sign_d = a_sign;
                ra_mag_d  = a_mag;
                ra_tag_d  = in_tag;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                ra_sign_q <= 1'b0;
                ra_mag_q  <= '0;
                ra_tag_q  <= '0;
            end else begin
                ra_sign_q <= ra_sign_d;
                ra_mag_q  <= ra_mag_d;
                ra_tag_q  <= ra_tag_d;
            end
        end

        assign bi_sign = ra_sign_q;
        assign bi_mag  = ra_mag_q;
        assign bi_tag  = ra_tag_q;
    end else begin : g_pass_a
        assign bi_sign = a_sign;
        assign bi_mag  = a_mag;
        assign bi_tag  = in_tag;
    end

    logic [LZW-1:0]   b_lz;
    logic             b_zero;
    logic [IW-1:0]    b_norm;
    logic [EXP_W-1:0] b_exp;

    itof_lzc #(.W(IW)) u_lzc (
        .d    (bi_mag),
        .cnt  (b_lz),
        .zero (b_zero)
    );

    // A zero operand gets a zero exponent here so stage C needs no separate zero path.
    always_comb begin
        b_norm = bi_mag << b_lz;
        b_exp  = b_zero ? '0 : (EXP_W'(BIAS + IW - 1) - EXP_W'(b_lz));
    end

    logic             ci_sign;
    logic [EXP_W-1:0] ci_exp;
    logic [IW-1:0]    ci_norm;
    logic [TAGW-1:0]  ci_tag;

    if (NSTAGE >= 2) begin : g_reg_b
        logic             rb_sign_q, rb_sign_d;
        logic [EXP_W-1:0] rb_exp_q, rb_exp_d;
        logic [IW-1:0]    rb_norm_q, rb_norm_d;
        logic [TAGW-1:0]  rb_tag_q, rb_tag_d;

        always_comb begin
            rb_sign_d = rb_sign_q;
            rb_exp_d  = rb_exp_q;
            rb_norm_d = rb_norm_q;
            rb_tag_d  = rb_tag_q;
            if (ld[NSTAGE-2]) begin
                rb_sign_d = bi_sign;
                rb_exp_d  = b_exp;
                rb_norm_d = b_norm;
                rb_tag_d  = bi_tag;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                rb_sign_q <= 1'b0;
                rb_exp_q  <= '0;
                rb_norm_q <= '0;
                rb_tag_q  <= '0;
            end else begin
                rb_sign_q <= rb_sign_d;
                rb_exp_q  <= rb_exp_d;
                rb_norm_q <= rb_norm_d;
                rb_tag_q  <= rb_tag_d;
            end
        end

        assign ci_sign = rb_sign_q;
        assign ci_exp  = rb_exp_q;
        assign ci_norm = rb_norm_q;
        assign ci_tag  = rb_tag_q;
    end else begin : g_pass_b
        assign ci_sign = bi_sign;
        assign ci_exp  = b_exp;
        assign ci_norm = b_norm;
        assign ci_tag  = bi_tag;
    end

    logic [NW-1:0]    c_ext;
    logic [MAN_W-1:0] c_frac;
    logic [MAN_W-1:0] c_man;
    logic             c_guard;
    logic             c_sticky;
    logic             c_up;
    logic             c_carry;
    result_t          res_q, res_d;
    logic [TAGW-1:0]  res_tag_q, res_tag_d;

    // Narrow operands are padded on the right so guard/sticky land in fixed positions and read zero.
    always_comb begin
        c_ext    = NW'(ci_norm) << PAD;
        c_frac   = c_ext[NW-2 -: MAN_W];
        c_guard  = c_ext[NW-MAN_W-2];
        c_sticky = |c_ext[NW-MAN_W-3:0];
        c_up     = c_guard & (c_sticky | c_frac[0]);
        {c_carry, c_man} = {1'b0, c_frac} + (MAN_W + 1)'(c_up);

        res_d     = res_q;
        res_tag_d = res_tag_q;
        if (ld[OUT_STG]) begin
            res_d.sign     = ci_sign & c_ext[NW-1];
            res_d.exponent = c_carry ? (ci_exp + EXP_W'(1)) : ci_exp;
            res_d.mantissa = c_man;
`ifdef ITOF_INEXACT_EN
            res_d.sticky   = c_guard | c_sticky;
`endif
            res_tag_d      = ci_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q       <= '0;
            res_q     <= '0;
            res_tag_q <= '0;
        end else begin
            v_q       <= v_d;
            res_q     <= res_d;
            res_tag_q <= res_tag_d;
        end
    end

    assign in_ready  = ready[0];
    assign out_valid = v_q[OUT_STG];
    assign out_data  = {res_q.sign, res_q.exponent, res_q.mantissa};
    assign out_tag   = res_tag_q;
`ifdef ITOF_INEXACT_EN
    assign out_inexact = res_q.sticky;
`endif

endmodule
